pacoblaze_idu_pipe: RTL and testbench

Registered, parametrised instruction decode stage for the next-generation PacoBlaze core. It sits between the program-ROM fetch stage and execute, with valid/ready handshakes on both sides. A 2-entry skid buffer (main + skid) allows full throughput with back-pressure. The stage adds flush support and illegal-opcode detection; the existing purely combinational decode has neither.

---
 rtl/pacoblaze_idu_pipe_if.sv | 50 +++++
 rtl/pacoblaze_idu_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_pacoblaze_idu_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pacoblaze_idu_pipe_if.sv
// Handshake and decoded-bundle bus for the PacoBlaze decode stage.
// The slave modport is the stage itself. The master modport is the fetch side
// driving instructions together with the execute side consuming bundles.
`timescale 1ns/1ps

interface pacoblaze_idu_pipe_if #(
    parameter int CODE_WIDTH     = 18,
    parameter int CODE_DEPTH     = 10,
    parameter int REGISTER_DEPTH = 4,
    parameter int SCRATCH_DEPTH  = 6,
    parameter int OPERAND_WIDTH  = 8
);
    // Fetch side
    logic                      in_valid;
    logic                      in_ready;
    logic [CODE_WIDTH-1:0]     instruction;

    // Execute side
    logic                      out_valid;
    logic                      out_ready;
    logic [4:0]                operation;
    logic                      illegal;
    logic                      operand_selection;
    logic [1:0]                condition_flags;
    logic [REGISTER_DEPTH-1:0] x_address;
    logic [REGISTER_DEPTH-1:0] y_address;
    logic [OPERAND_WIDTH-1:0]  implied_value;
    logic [SCRATCH_DEPTH-1:0]  scratch_address;
    logic [CODE_DEPTH-1:0]     code_address;
    logic                      shift_direction;
    logic [1:0]                shift_operation;
    logic                      shift_constant;
    logic                      interrupt_enable;

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, operation, illegal, operand_selection,
               condition_flags, x_address, y_address, implied_value,
               scratch_address, code_address, shift_direction,
               shift_operation, shift_constant, interrupt_enable
    );

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, operation, illegal, operand_selection,
               condition_flags, x_address, y_address, implied_value,
               scratch_address, code_address, shift_direction,
               shift_operation, shift_constant, interrupt_enable
    );
endinterface

// File: rtl/pacoblaze_idu_pipe.sv
// PacoBlaze registered instruction decode stage.
// The input word is decoded combinationally. The result is then held in a
// two-entry skid buffer (main and skid) that sits between fetch and execute.
// The buffer is FIFO ordered, and it runs at full throughput even when
// execute applies back-pressure. Flush discards every held bundle.
// Optional build macro PACOBLAZE_IDU_STATS_EN adds two ports: a handshake
// counter (decode_count) and a saturating illegal-opcode counter
// (illegal_count).
`timescale 1ns/1ps

module pacoblaze_idu_pipe #(
    parameter int CODE_WIDTH     = 18,
    parameter int CODE_DEPTH     = 10,
    parameter int REGISTER_DEPTH = 4,
    parameter int SCRATCH_DEPTH  = 6,
    parameter int OPERAND_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pacoblaze_idu_pipe_if.slave   bus
`ifdef PACOBLAZE_IDU_STATS_EN
    ,
    output logic [15:0]           decode_count,
    output logic [7:0]            illegal_count
`endif
);

    typedef struct packed {
        logic [4:0]                operation;
        logic                      illegal;
        logic                      operand_selection;
        logic [1:0]                condition_flags;
        logic [REGISTER_DEPTH-1:0] x_address;
        logic [REGISTER_DEPTH-1:0] y_address;
        logic [OPERAND_WIDTH-1:0]  implied_value;
        logic [SCRATCH_DEPTH-1:0]  scratch_address;
        logic [CODE_DEPTH-1:0]     code_address;
        logic                      shift_direction;
        logic [1:0]                shift_operation;
        logic                      shift_constant;
        logic                      interrupt_enable;
    } bundle_t;

    // Encoding is {main_valid, skid_valid}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_in_ready;
    bundle_t    r_main;
    bundle_t    r_skid;
    bundle_t    w_dec;
    logic [4:0] w_opcode;
    logic       w_legal;
    logic       w_accept;
    logic       w_load_main;
    logic       w_load_skid;
    logic       w_skid_to_main;

    assign w_opcode = bus.instruction[CODE_WIDTH-1 -: 5];
    assign w_accept = bus.in_valid && r_in_ready;

    // Decode the offered word into a bundle; illegal opcodes report operation 0.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_dec   = '0;
        w_legal = 1'b0;
        case (w_opcode)
            5'h00, 5'h02, 5'h03, 5'h05, 5'h06, 5'h07, 5'h09, 5'h0A,
            5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h15, 5'h16, 5'h17,
            5'h18, 5'h1A, 5'h1C, 5'h1E: w_legal = 1'b1;
            default:                    w_legal = 1'b0;
        endcase
        w_dec.operation         = w_legal ? w_opcode : 5'h00;
        w_dec.illegal           = !w_legal;
        w_dec.operand_selection = bus.instruction[CODE_WIDTH-6];
        w_dec.condition_flags   = bus.instruction[CODE_WIDTH-7 -: 2];
        w_dec.x_address         = bus.instruction[2*REGISTER_DEPTH+3 -: REGISTER_DEPTH];
        w_dec.y_address         = bus.instruction[REGISTER_DEPTH+3 -: REGISTER_DEPTH];
        w_dec.implied_value     = bus.instruction[OPERAND_WIDTH-1:0];
        w_dec.scratch_address   = bus.instruction[SCRATCH_DEPTH-1:0];
        w_dec.code_address      = bus.instruction[CODE_DEPTH-1:0];
        w_dec.shift_direction   = bus.instruction[3];
        w_dec.shift_operation   = bus.instruction[2:1];
        w_dec.shift_constant    = bus.instruction[0];
        w_dec.interrupt_enable  = bus.instruction[0];
    end

    // Next-state and buffer steering; flush overrides every transition.
    always_comb begin
        w_state_next   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_load_main  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && bus.out_ready) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (bus.out_ready) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        w_state_next   = ST_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered as "skid will be empty".
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    // Bundle registers: main feeds the outputs, skid catches the overflow.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset so that the outputs read 0 after
        // reset. Flush leaves them untouched, because only the valid bits
        // decide what the registers mean.
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_dec;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign bus.in_ready          = r_in_ready;
    assign bus.out_valid         = (r_state != ST_EMPTY);
    assign bus.operation         = r_main.operation;
    assign bus.illegal           = r_main.illegal;
    assign bus.operand_selection = r_main.operand_selection;
    assign bus.condition_flags   = r_main.condition_flags;
    assign bus.x_address         = r_main.x_address;
    assign bus.y_address         = r_main.y_address;
    assign bus.implied_value     = r_main.implied_value;
    assign bus.scratch_address   = r_main.scratch_address;
    assign bus.code_address      = r_main.code_address;
    assign bus.shift_direction   = r_main.shift_direction;
    assign bus.shift_operation   = r_main.shift_operation;
    assign bus.shift_constant    = r_main.shift_constant;
    assign bus.interrupt_enable  = r_main.interrupt_enable;

`ifdef PACOBLAZE_IDU_STATS_EN
    logic [15:0] r_decode_count;
    logic [7:0]  r_illegal_count;
    logic        w_handshake;

    assign w_handshake = (r_state != ST_EMPTY) && bus.out_ready;

    // Count delivered bundles (wrapping) and illegal ones (saturating).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_decode_count  <= '0;
            r_illegal_count <= '0;
        end else if (w_handshake) begin
            r_decode_count <= r_decode_count + 16'd1;
            if (r_main.illegal && (r_illegal_count != 8'hFF)) begin
                r_illegal_count <= r_illegal_count + 8'd1;
            end
        end
    end

    assign decode_count  = r_decode_count;
    assign illegal_count = r_illegal_count;
`endif

endmodule

// File: tb/tb_pacoblaze_idu_pipe.sv
// Self-checking bench for pacoblaze_idu_pipe.
// The driver pushes the hand-computed expected bundle of each accepted word
// into a queue. A separate monitor pops and compares on every handshake.
// Build with PACOBLAZE_IDU_STATS_EN to also exercise the counters.
`timescale 1ns/1ps

module tb_pacoblaze_idu_pipe;

    typedef struct {
        logic [17:0] w;
        logic [4:0]  op;
        logic        ill;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [7:0]  imm;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_hs     = 0;
    logic [7:0] n_ill = '0;
    vec_t exp_q[$];

    pacoblaze_idu_pipe_if #(
        .CODE_WIDTH(18), .CODE_DEPTH(10), .REGISTER_DEPTH(4),
        .SCRATCH_DEPTH(6), .OPERAND_WIDTH(8)
    ) dut_if ();

`ifdef PACOBLAZE_IDU_STATS_EN
    logic [15:0] decode_count;
    logic [7:0]  illegal_count;
`endif

    pacoblaze_idu_pipe #(
        .CODE_WIDTH(18), .CODE_DEPTH(10), .REGISTER_DEPTH(4),
        .SCRATCH_DEPTH(6), .OPERAND_WIDTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (dut_if)
`ifdef PACOBLAZE_IDU_STATS_EN
        ,
        .decode_count  (decode_count),
        .illegal_count (illegal_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic [17:0] w, input logic [4:0] op, input logic ill,
                               input logic [3:0] x, input logic [3:0] y, input logic [7:0] imm);
        vec_t r;
        r.w = w; r.op = op; r.ill = ill; r.x = x; r.y = y; r.imm = imm;
        return r;
    endfunction

    // Expected bundle: the hand-computed fields come from the table, and the
    // remaining fields are plain bit-slices of the word.
    function automatic logic [45:0] exp_bundle(input vec_t e);
        return {e.op, e.ill, e.x, e.y, e.imm, e.w[9:0], e.w[5:0], e.w[12],
                e.w[11:10], e.w[3], e.w[2:1], e.w[0], e.w[0]};
    endfunction

    function automatic logic [45:0] act_bundle();
        return {dut_if.operation, dut_if.illegal, dut_if.x_address, dut_if.y_address,
                dut_if.implied_value, dut_if.code_address, dut_if.scratch_address,
                dut_if.operand_selection, dut_if.condition_flags, dut_if.shift_direction,
                dut_if.shift_operation, dut_if.shift_constant, dut_if.interrupt_enable};
    endfunction

    // Monitor: score each handshake and verify the bundle holds while stalled.
    logic [45:0] prev_bundle = '0;
    bit          prev_stall  = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && dut_if.out_valid)
                check("hold_stable", 64'(act_bundle()), 64'(prev_bundle));
            if (dut_if.out_valid && dut_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(act_bundle()), 64'hDEAD);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    check("bundle", 64'(act_bundle()), 64'(exp_bundle(e)));
                    n_hs++;
                    if (e.ill && n_ill != 8'hFF) n_ill = n_ill + 8'd1;
                end
            end
        end
        prev_stall  = !reset && !flush && dut_if.out_valid && !dut_if.out_ready;
        prev_bundle = act_bundle();
    end

    // Offer one word for a cycle; the call starts and ends just after posedge.
    task automatic send(input vec_t e, input bit fl = 1'b0);
        bit acc;
        dut_if.in_valid    = 1'b1;
        dut_if.instruction = e.w;
        flush              = fl;
        @(negedge clk);
        acc = dut_if.in_ready && !fl;
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(e);
        #1;
        dut_if.in_valid = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic idle(input int n);
        dut_if.in_valid = 1'b0;
        flush           = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t stream[8];
        vec_t add_s1, il01, f_a, f_b, c_a, c_b, c_c, drop_w;
        int   hs0;

        // add s1, 0x55: opcode 0C in [17:13], x=1 in [11:8], k in [7:0] -> 0x18155
        add_s1    = v(18'h18155, 5'h0C, 1'b0, 4'h1, 4'h5, 8'h55);
        stream[0] = v(18'h00A3C, 5'h00, 1'b0, 4'hA, 4'h3, 8'h3C); // load: field 00 stays legal
        stream[1] = v(18'h04210, 5'h02, 1'b0, 4'h2, 4'h1, 8'h10); // input
        stream[2] = v(18'h0F3FF, 5'h07, 1'b0, 4'h3, 4'hF, 8'hFF); // xor, sel=1
        stream[3] = v(18'h1C5AA, 5'h0E, 1'b0, 4'h5, 4'hA, 8'hAA); // sub
        stream[4] = v(18'h20007, 5'h10, 1'b0, 4'h0, 4'h0, 8'h07); // rs
        stream[5] = v(18'h2A000, 5'h15, 1'b0, 4'h0, 4'h0, 8'h00); // return
        stream[6] = v(18'h34123, 5'h1A, 1'b0, 4'h1, 4'h2, 8'h23); // jump 0x123
        stream[7] = v(18'h3E000, 5'h00, 1'b1, 4'h0, 4'h0, 8'h00); // field 1F illegal
        f_a    = v(18'h2C47E, 5'h16, 1'b0, 4'h4, 4'h7, 8'h7E);    // output
        f_b    = v(18'h2E9C1, 5'h17, 1'b0, 4'h9, 4'hC, 8'hC1);    // store
        c_a    = v(18'h30055, 5'h18, 1'b0, 4'h0, 4'h5, 8'h55);    // call
        c_b    = v(18'h38001, 5'h1C, 1'b0, 4'h0, 4'h0, 8'h01);    // returni
        c_c    = v(18'h3C001, 5'h1E, 1'b0, 4'h0, 4'h0, 8'h01);    // interrupt
        drop_w = v(18'h1A0FF, 5'h0D, 1'b0, 4'h0, 4'hF, 8'hFF);    // addcy, must be dropped
        il01   = v(18'h02000, 5'h00, 1'b1, 4'h0, 4'h0, 8'h00);    // field 01 illegal

        reset              = 1'b1;
        flush              = 1'b0;
        dut_if.in_valid    = 1'b0;
        dut_if.instruction = '0;
        dut_if.out_ready   = 1'b0;

        // Reset held 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("in_ready_in_reset", 64'(dut_if.in_ready), 64'd0);
        check("out_valid_in_reset", 64'(dut_if.out_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 64'(dut_if.in_ready), 64'd1);
        check("out_valid_after_reset", 64'(dut_if.out_valid), 64'd0);
        check("bundle_after_reset", 64'(act_bundle()), 64'd0);

        // Single add with one-cycle latency
        dut_if.out_ready = 1'b1;
        send(add_s1);
        check("latency_out_valid", 64'(dut_if.out_valid), 64'd1);
        idle(1);
        wait_drain();

        // Eight back-to-back words: in_ready stays high, outputs on consecutive cycles
        hs0 = n_hs;
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", 64'(dut_if.in_ready), 64'd1);
            send(stream[i]);
        end
        idle(1);
        check("stream_handshakes", 64'(n_hs - hs0), 64'd8);
        wait_drain();

        // Back-pressure: two words fill main+skid, then drain in order
        dut_if.out_ready = 1'b0;
        send(f_a);
        send(f_b);
        check("full_in_ready", 64'(dut_if.in_ready), 64'd0);
        check("full_out_valid", 64'(dut_if.out_valid), 64'd1);
        idle(2);
        check("full_head_op", 64'(dut_if.operation), 64'h16);
        hs0 = n_hs;
        dut_if.out_ready = 1'b1;
        idle(2);
        check("full_drain_count", 64'(n_hs - hs0), 64'd2);
        check("full_drain_empty", 64'(dut_if.out_valid), 64'd0);
        wait_drain();

        // Flush while FULL with a word offered
        dut_if.out_ready = 1'b0;
        send(c_a);
        send(c_b);
        check("pre_flush_full", 64'(dut_if.in_ready), 64'd0);
        send(drop_w, 1'b1);
        check("flush_full_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("flush_full_in_ready", 64'(dut_if.in_ready), 64'd1);
        hs0 = n_hs;
        dut_if.out_ready = 1'b1;
        idle(3);
        check("flush_full_no_output", 64'(n_hs - hs0), 64'd0);

        // Flush while ONE with an acceptable word offered: word is dropped
        dut_if.out_ready = 1'b0;
        send(c_c);
        check("pre_flush_one", 64'(dut_if.in_ready), 64'd1);
        send(drop_w, 1'b1);
        check("flush_one_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("flush_one_in_ready", 64'(dut_if.in_ready), 64'd1);
        hs0 = n_hs;
        dut_if.out_ready = 1'b1;
        idle(3);
        check("flush_one_no_output", 64'(n_hs - hs0), 64'd0);

        // Illegal opcode field 01
        send(il01);
        idle(1);
        wait_drain();

`ifdef PACOBLAZE_IDU_STATS_EN
        // Counters track handshakes so far and were untouched by flush
        check("stats_decode_running", 64'(decode_count), 64'(n_hs[15:0]));
        check("stats_illegal_running", 64'(illegal_count), 64'(n_ill));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        n_hs  = 0;
        n_ill = '0;
        @(posedge clk);
        #1;
        check("stats_reset_decode", 64'(decode_count), 64'd0);
        check("stats_reset_illegal", 64'(illegal_count), 64'd0);

        dut_if.out_ready = 1'b1;
        send(il01);
        idle(1);
        wait_drain();
        check("stats_illegal_one", 64'(illegal_count), 64'd1);
        check("stats_decode_one", 64'(decode_count), 64'd1);

        for (int i = 0; i < 299; i++) send(il01);
        idle(1);
        wait_drain();
        check("stats_illegal_sat", 64'(illegal_count), 64'hFF);
        check("stats_decode_300", 64'(decode_count), 64'h012C);

        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("stats_flush_keeps", 64'(decode_count), 64'h012C);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
